// File: rtl/str_pkg.sv
// Shared definitions for the stream-rate blocks (str_interp, str_deci).
package str_pkg;

    typedef enum logic {
        FILL_ZERO,
        FILL_HOLD
    } fill_mode_e;

    // Counter width for a modulo-n count; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mod_cnt.sv
// Modulo-N counter with synchronous clear; wrap flags the enabled step from N-1 back to 0.
module mod_cnt
    import str_pkg::*;
#(
    parameter int unsigned N = 5,
    localparam int unsigned W = cnt_w(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] Last = W'(N - 1);

    logic [W-1:0] cnt_q;

    assign cnt  = cnt_q;
    assign wrap = en & (cnt_q == Last);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == Last) ? '0 : cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/str_interp.sv
// Stream interpolator: each accepted sample becomes R output beats, zero-stuffed or held.
module str_interp
    import str_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned R    = 5,
    parameter int unsigned HOLD = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_first
);

    localparam int unsigned PW        = cnt_w(R);
    localparam logic [PW-1:0] LastPh  = PW'(R - 1);
    localparam fill_mode_e Fill       = (HOLD != 0) ? FILL_HOLD : FILL_ZERO;

    logic [DW-1:0] data_q;
    logic [PW-1:0] phase_q;
    logic          busy_q, busy_d;
    logic          in_fire, out_fire, last_ph, wrap;

    assign last_ph   = (phase_q == LastPh);
    // Combinational out_ready -> in_ready lets the next group start with no bubble.
    assign in_ready  = rst_n & (~busy_q | (out_ready & last_ph));
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = busy_q & out_ready;
    assign out_valid = busy_q;
    assign out_first = busy_q & (phase_q == '0);
    assign out_data  = ((Fill == FILL_HOLD) || (phase_q == '0)) ? data_q : '0;

    mod_cnt #(
        .N (R)
    ) u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (in_fire),
        .en    (out_fire),
        .cnt   (phase_q),
        .wrap  (wrap)
    );

    always_comb begin
        busy_d = busy_q;
        if (in_fire) begin
            busy_d = 1'b1;
        end else if (wrap) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            data_q <= '0;
        end else begin
            busy_q <= busy_d;
            if (in_fire) begin
                data_q <= in_data;
            end
        end
    end

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> $stable(out_data));

    logic [31:0] beats_q;
    logic        seen_q;

    // A reload edge may carry the previous group's last beat, so count it in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beats_q <= '0;
            seen_q  <= 1'b0;
        end else if (in_fire) begin
            assert (!seen_q || (beats_q + {31'd0, out_fire}) == 32'(R));
            beats_q <= '0;
            seen_q  <= 1'b1;
        end else if (out_fire) begin
            beats_q <= beats_q + 32'd1;
        end
    end
`endif

endmodule

// File: doc/str_interp.md
# str_interp

Stream interpolator (upsampler) that is the counterpart to the `str_deci` stream decimator. Each input sample accepted on a valid/ready stream becomes `R` output beats, either zero-stuffed or zero-order-held, on a second valid/ready stream. It sits at the output side of the LPDAQ stream chain, where rates are raised again, and can be cascaded stage by stage like the decimators. Throughput is one output beat per clock while downstream is ready.

## Interface
- `DW`, 32: sample width in bits, DW ≥ 1.
- `R`, 5: interpolation ratio, R ≥ 1. R = 1 is a registered pass-through.
- `HOLD`, 0: fill mode. 0 = zero-stuff, so beats 1..R-1 are 0. 1 = hold, so every beat repeats the sample.
- `clk` input 1: clock. All state changes on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_data` input DW: input sample.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block accepts `in_data` this cycle.
- `out_data` output DW: output beat.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: downstream accepts the beat.
- `out_first` output 1: marks beat 0 of each group of R beats (the original sample).

## Operation
- Handshakes: `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- Registers:
  - `data_q`: DW bits, the captured sample.
  - `phase_q`: width `$clog2(R)`, minimum 1 bit; counts 0..R-1.
  - `busy_q`: drives `out_valid`.
- States, implied by `busy_q`:
  - IDLE (`busy_q` = 0) → BUSY on `in_fire`.
  - BUSY → BUSY while `phase_q` < R-1, or on a reload at the last beat.
  - BUSY → IDLE on `out_fire` at `phase_q` == R-1 with no `in_fire`.
- `in_ready = rst_n & (~busy_q | (out_ready & phase_q == R-1))`. This gives a combinational path from `out_ready` to `in_ready`, which is intended and allows gap-free back-to-back groups.
- On `in_fire`: `data_q` ← `in_data`, `phase_q` ← 0, `busy_q` ← 1. `in_fire` takes priority over the phase update from `out_fire`.
- Else on `out_fire`:
  - if `phase_q` == R-1: `busy_q` ← 0 and `phase_q` ← 0;
  - otherwise `phase_q` increments by 1.
- `out_data` = `data_q` when HOLD = 1 or `phase_q` == 0; otherwise all zeros.
- `out_first = busy_q & (phase_q == 0)`.
- Stalls: while `out_valid` = 1 and `out_ready` = 0, `out_data`, `out_first` and `phase_q` hold, and `in_ready` = 0.
- Samples are never dropped or duplicated. Exactly R beats are emitted per accepted sample.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_first` 0, `phase_q` 0, `data_q` 0. `in_ready` is 0 while `rst_n` = 0 and becomes 1 in the first cycle after reset is released.
- Latency: a sample accepted at edge k appears as beat 0 in the cycle after edge k.
- Sustained rates:
  - output: one beat per cycle when `out_ready` = 1;
  - input: one sample every R cycles when both sides are always ready.
- R = 1: `in_ready = ~busy_q | out_ready`. This behaves as a one-stage pipeline register with full throughput.
- Reset mid-group: the group is abandoned. `out_valid` drops at the next edge and no partial-group completion occurs.
- A simultaneous `in_fire` and last-beat `out_fire` reloads in the same edge, with no idle cycle between groups.

## Structure
- Shared package `str_pkg`:
  - function `cnt_w(int n)` returning `max(1, $clog2(n))`, shared with `str_deci`;
  - typedef `fill_mode_e {FILL_ZERO, FILL_HOLD}`, usable in place of the HOLD integer.
- One natural sub-module, `mod_cnt`: a modulo-N counter with `clr`, `en` and a `wrap` output, also reusable by `str_deci`. `str_interp` instantiates it for `phase_q`.
- Embedded assertions:
  - `out_valid & ~out_ready` ⇒ `out_data` is stable in the next cycle;
  - every `in_fire` is followed by exactly R `out_fire` before the next `out_first`.

## Test plan
- Reset release, R = 5, HOLD = 0, `in_valid` = 1 with `in_data` = 1, 2, 3, `out_ready` = 1. Required output: 1,0,0,0,0,2,0,0,0,0,3…, with `out_first` on every 5th beat and `in_ready` high once every 5 cycles.
- R = 4, HOLD = 1, input 0xA then 0xB. Required output: A,A,A,A,B,B,B,B with no bubble between the groups.
- Backpressure at R = 5: drop `out_ready` for 3 cycles at phase 2. `out_data` and the phase hold, `in_ready` stays 0, and the sequence resumes unchanged.
- R = 1: a continuous ramp 0..99 with random `out_ready`. The output equals the input ramp, in order and without loss.
- Reset asserted at phase 3 of a group. `out_valid` is 0 at the next edge, and the next input after reset starts at phase 0.
- Cascade `str_interp` (R = 6) → `str_deci` (R = 6) with HOLD = 1. The output equals the input stream exactly.
